// File: rtl/atan2_pkg.sv
// Shared types and angle constants for the quadrant-unfolding atan2 wrapper.
// Angles are Q1.(w-1) fractions of pi, so +1.0 is not representable.
package atan2_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

  typedef enum logic [1:0] {QUAD_1, QUAD_2, QUAD_3, QUAD_4} quad_t;

  function automatic quad_t to_quad(input logic sx, input logic sy);
    case ({sx, sy})
      2'b00:   return QUAD_1;
      2'b10:   return QUAD_2;
      2'b11:   return QUAD_3;
      default: return QUAD_4;
    endcase
  endfunction

  function automatic logic [31:0] ANG_POS_MAX(input int w);
    return (32'd1 << (w - 1)) - 32'd1;
  endfunction

  function automatic logic [31:0] ANG_NEG_ONE(input int w);
    return 32'd1 << (w - 1);
  endfunction

  function automatic logic [31:0] ANG_ZERO(input int w);
    return (w > 0) ? 32'd0 : 32'd0;
  endfunction

endpackage

// File: rtl/atan2_quadrant_if.sv
// Upstream sample, first-quadrant core and downstream result channels.
// The slave modport is the wrapper's view; master is the surrounding system.
interface atan2_quadrant_if #(
  parameter int DIN_WIDTH  = 16,
  parameter int DOUT_WIDTH = 16
) ();

  logic signed [DIN_WIDTH-1:0]  x_in;
  logic signed [DIN_WIDTH-1:0]  y_in;
  logic                         din_valid;
  logic                         din_ready;
  logic        [DIN_WIDTH-1:0]  core_x;
  logic        [DIN_WIDTH-1:0]  core_y;
  logic                         core_valid;
  logic                         core_ready;
  logic signed [DOUT_WIDTH-1:0] core_z;
  logic                         core_z_valid;
  logic signed [DOUT_WIDTH-1:0] dout;
  logic                         dout_valid;
  logic                         dout_ready;
  logic                         err;

  modport slave (
    input  x_in, y_in, din_valid, core_ready, core_z, core_z_valid, dout_ready,
    output din_ready, core_x, core_y, core_valid, dout, dout_valid, err
  );

  modport master (
    output x_in, y_in, din_valid, core_ready, core_z, core_z_valid, dout_ready,
    input  din_ready, core_x, core_y, core_valid, dout, dout_valid, err
  );

endinterface

// File: rtl/atan2_unfold.sv
// Maps a first-quadrant core angle back to the sample's true quadrant,
// computing one guard bit wide and saturating to the Q1 output range.
module atan2_unfold
  import atan2_pkg::*;
#(
  parameter int DOUT_WIDTH = 16
) (
  input  quad_t                        quad,
  input  logic signed [DOUT_WIDTH-1:0] z,
  output logic signed [DOUT_WIDTH-1:0] angle
);

  localparam logic signed [DOUT_WIDTH-1:0] POS_MAX = DOUT_WIDTH'(ANG_POS_MAX(DOUT_WIDTH));
  localparam logic signed [DOUT_WIDTH-1:0] NEG_ONE = DOUT_WIDTH'(ANG_NEG_ONE(DOUT_WIDTH));
  localparam logic signed [DOUT_WIDTH:0]   EXT_MAX = {1'b0, POS_MAX};
  localparam logic signed [DOUT_WIDTH:0]   EXT_MIN = {1'b1, NEG_ONE};
  // +1.0 (pi) only exists in the widened domain
  localparam logic signed [DOUT_WIDTH:0]   ONE     = {2'b01, {(DOUT_WIDTH-1){1'b0}}};

  function automatic logic signed [DOUT_WIDTH-1:0] sat(input logic signed [DOUT_WIDTH:0] v);
    if (v > EXT_MAX)      return POS_MAX;
    else if (v < EXT_MIN) return NEG_ONE;
    else                  return v[DOUT_WIDTH-1:0];
  endfunction

  logic signed [DOUT_WIDTH:0] ze;
  logic signed [DOUT_WIDTH:0] r;

  always_comb begin
    ze = {z[DOUT_WIDTH-1], z};
    r  = ze;
    case (quad)
      QUAD_1:  r = ze;
      QUAD_2:  r = ONE - ze;
      QUAD_3:  r = ze - ONE;
      QUAD_4:  r = -ze;
      default: r = ze;
    endcase
    angle = sat(r);
  end

endmodule

// File: rtl/atan2_quadrant.sv
// Folds a signed sample into the first quadrant, hands it to an external
// atan core and unfolds the returned angle; one sample in flight at a time.
module atan2_quadrant
  import atan2_pkg::*;
#(
  parameter int DIN_WIDTH  = 16,
  parameter int DOUT_WIDTH = 16,
  parameter int TIMEOUT    = 2*DIN_WIDTH+4
) (
  input logic              clk,
  input logic              rst_n,
  atan2_quadrant_if.slave  bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic signed [DOUT_WIDTH-1:0] POS_MAX = DOUT_WIDTH'(ANG_POS_MAX(DOUT_WIDTH));
  localparam logic signed [DOUT_WIDTH-1:0] ZERO    = DOUT_WIDTH'(ANG_ZERO(DOUT_WIDTH));

  state_t                       state, state_nxt;
  logic [CNT_W-1:0]             cnt;
  logic                         sx, sy;
  logic                         accept, byp_zero, byp_neg, timeout_hit;
  logic [DIN_WIDTH-1:0]         ax, ay;
  logic signed [DOUT_WIDTH-1:0] angle;

  assign bus.din_ready  = (state == IDLE) && rst_n;
  assign bus.core_valid = (state == ISSUE);
  assign bus.dout_valid = (state == OUT);

  assign accept      = bus.din_valid && bus.din_ready;
  assign byp_zero    = (bus.x_in == '0) && (bus.y_in == '0);
  assign byp_neg     = (bus.y_in == '0) && bus.x_in[DIN_WIDTH-1];
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

  // Two's-complement negate; the most negative input folds to 2^(DIN_WIDTH-1)
  assign ax = bus.x_in[DIN_WIDTH-1] ? -bus.x_in : bus.x_in;
  assign ay = bus.y_in[DIN_WIDTH-1] ? -bus.y_in : bus.y_in;

  atan2_unfold #(.DOUT_WIDTH(DOUT_WIDTH)) u_unfold (
    .quad  (to_quad(sx, sy)),
    .z     (bus.core_z),
    .angle (angle)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (byp_zero || byp_neg) ? OUT : ISSUE;
      ISSUE:   if (bus.core_ready) state_nxt = WAIT;
      WAIT:    if (bus.core_z_valid || timeout_hit) state_nxt = OUT;
      OUT:     if (bus.dout_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.core_x <= '0;
      bus.core_y <= '0;
      bus.dout   <= '0;
      bus.err    <= 1'b0;
      sx         <= 1'b0;
      sy         <= 1'b0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          bus.core_x <= ax;
          bus.core_y <= ay;
          sx         <= bus.x_in[DIN_WIDTH-1];
          sy         <= bus.y_in[DIN_WIDTH-1];
          cnt        <= '0;
          bus.err    <= 1'b0;
          if (byp_zero)     bus.dout <= ZERO;
          else if (byp_neg) bus.dout <= POS_MAX;
        end
        WAIT: begin
          if (bus.core_z_valid) begin
            bus.dout <= angle;
            bus.err  <= 1'b0;
          end else if (timeout_hit) begin
            bus.dout <= ZERO;
            bus.err  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
